// File: rtl/ifu_fetch_if.sv
// Fetch-side bundle: pcGen address handshake, memory request/response,
// instruction-queue credit, delivery to the instruction queue and flush.
interface ifu_fetch_if #(
    parameter int DW = 64
);
    logic [63:0]   fetch_addr_qout;
    logic          fetch_addr_valid;
    logic          fetch_addr_ready;
    logic          ifu_mstReq_valid;
    logic          ifu_mstReq_ready;
    logic [63:0]   ifu_addr;
    logic          ifu_slvRsp_valid;
    logic [DW-1:0] ifu_data_r;
    logic [4:0]    iq_free;
    logic [63:0]   fetch_pc;
    logic [DW-1:0] fetch_instr;
    logic          fetch_valid;
    logic          rsp_err;
    logic          flush;

    modport master (
        input  fetch_addr_qout, fetch_addr_valid, ifu_mstReq_ready,
        input  ifu_slvRsp_valid, ifu_data_r, iq_free, flush,
        output fetch_addr_ready, ifu_mstReq_valid, ifu_addr,
        output fetch_pc, fetch_instr, fetch_valid, rsp_err
    );

    modport slave (
        output fetch_addr_qout, fetch_addr_valid, ifu_mstReq_ready,
        output ifu_slvRsp_valid, ifu_data_r, iq_free, flush,
        input  fetch_addr_ready, ifu_mstReq_valid, ifu_addr,
        input  fetch_pc, fetch_instr, fetch_valid, rsp_err
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch request sequencer: issues pcGen addresses to memory, tracks
// in-flight PCs in order, and drops responses belonging to flushed requests.
module ifu_fetch_ctrl #(
    parameter int          DW     = 64,
    parameter int          OUTSTD = 4,
    parameter logic [63:0] RST_PC = 64'h0000_0000_8000_0000
) (
    input  logic       CLK,
    input  logic       RSTn,
    ifu_fetch_if.master bus
);
    localparam int PW = $clog2(OUTSTD);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_C = CW'(OUTSTD);

    logic [CW-1:0]   inflight_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [63:0]     addr_mem_r [OUTSTD];
    logic [OUTSTD-1:0] stale_r;
    logic [63:0]     fetch_pc_r;
    logic [DW-1:0]   fetch_instr_r;
    logic            fetch_valid_r;
    logic            rsp_err_r;

    logic [5:0]        credit_use_s;
    logic              can_issue_s;
    logic              req_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              orphan_rsp_s;
    logic [OUTSTD-1:0] inflight_mask_s;

    // The word being delivered this cycle still occupies an IQ slot next cycle.
    assign credit_use_s = 6'(inflight_r) + 6'(fetch_valid_r);
    assign can_issue_s  = (inflight_r < MAX_C) && (credit_use_s < {1'b0, bus.iq_free}) && !bus.flush;
    assign req_valid_s  = bus.fetch_addr_valid && can_issue_s;
    assign push_s       = req_valid_s && bus.ifu_mstReq_ready;
    assign pop_s        = bus.ifu_slvRsp_valid && (inflight_r != {CW{1'b0}});
    assign orphan_rsp_s = bus.ifu_slvRsp_valid && (inflight_r == {CW{1'b0}});

    assign bus.ifu_mstReq_valid = req_valid_s;
    assign bus.fetch_addr_ready = push_s;
    assign bus.ifu_addr         = bus.fetch_addr_qout;
    assign bus.fetch_pc         = fetch_pc_r;
    assign bus.fetch_instr      = fetch_instr_r;
    assign bus.fetch_valid      = fetch_valid_r;
    assign bus.rsp_err          = rsp_err_r;

    // Marks FIFO slots lying between rd_ptr and rd_ptr+inflight (modulo depth).
    always_comb begin
        inflight_mask_s = {OUTSTD{1'b0}};
        for (int i = 0; i < OUTSTD; i++) begin
            inflight_mask_s[i] = ({1'b0, PW'(PW'(i) - rd_ptr_r)} < inflight_r);
        end
    end

    // FIFO pointers, occupancy, stale tags and registered delivery outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            inflight_r    <= {CW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            stale_r       <= {OUTSTD{1'b0}};
            for (int i = 0; i < OUTSTD; i++) begin
                addr_mem_r[i] <= 64'h0;
            end
            fetch_pc_r    <= RST_PC;
            fetch_instr_r <= {DW{1'b0}};
            fetch_valid_r <= 1'b0;
            rsp_err_r     <= 1'b0;
        end else begin
            if (push_s) begin
                addr_mem_r[wr_ptr_r] <= bus.fetch_addr_qout;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end

            // Push never coincides with flush, so the two stale updates are exclusive.
            if (bus.flush) begin
                stale_r <= stale_r | inflight_mask_s;
            end else if (push_s) begin
                stale_r[wr_ptr_r] <= 1'b0;
            end

            if (pop_s) begin
                rd_ptr_r      <= rd_ptr_r + PW'(1);
                fetch_pc_r    <= addr_mem_r[rd_ptr_r];
                fetch_instr_r <= bus.ifu_data_r;
            end

            case ({push_s, pop_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase

            fetch_valid_r <= pop_s && !stale_r[rd_ptr_r] && !bus.flush;

            if (orphan_rsp_s) begin
                rsp_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed testbench for ifu_fetch_ctrl with hand-computed expectations.
module tb_ifu_fetch_ctrl;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    ifu_fetch_if #(.DW(64)) bus ();

    ifu_fetch_ctrl #(.DW(64), .OUTSTD(4), .RST_PC(RST_PC)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        bus.fetch_addr_qout  = 64'h0;
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_mstReq_ready = 1'b1;
        bus.ifu_slvRsp_valid = 1'b0;
        bus.ifu_data_r       = 64'h0;
        bus.iq_free          = 5'd8;
        bus.flush            = 1'b0;

        // Reset state
        #1 RSTn = 1'b0;
        #2;
        chk("rst_pc", bus.fetch_pc, RST_PC);
        chk("rst_instr", bus.fetch_instr, 64'h0);
        chk("rst_fv", 64'(bus.fetch_valid), 64'h0);
        chk("rst_err", 64'(bus.rsp_err), 64'h0);
        tick();
        RSTn = 1'b1;
        tick();

        // Basic two-request fetch
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h8000_0000;
        #1;
        chk("t1_req_valid", 64'(bus.ifu_mstReq_valid), 64'h1);
        chk("t1_addr", bus.ifu_addr, 64'h8000_0000);
        chk("t1_ready0", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_qout = 64'h8000_0008;
        #1 chk("t1_ready1", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_valid = 1'b0;
        tick();
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h13;
        tick();
        chk("t1_fv0", 64'(bus.fetch_valid), 64'h1);
        chk("t1_pc0", bus.fetch_pc, 64'h8000_0000);
        chk("t1_instr0", bus.fetch_instr, 64'h13);
        bus.ifu_data_r = 64'h93;
        tick();
        chk("t1_fv1", 64'(bus.fetch_valid), 64'h1);
        chk("t1_pc1", bus.fetch_pc, 64'h8000_0008);
        chk("t1_instr1", bus.fetch_instr, 64'h93);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();
        chk("t1_fv_low", 64'(bus.fetch_valid), 64'h0);
        chk("t1_inflight", 64'(dut.inflight_r), 64'h0);

        // Fill to OUTSTD, then free a slot with a response
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h1000;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("t2_accept%0d", i), 64'(bus.fetch_addr_ready), (i < 4) ? 64'h1 : 64'h0);
            tick();
            if (i < 4) bus.fetch_addr_qout = bus.fetch_addr_qout + 64'h8;
        end
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h21;
        #1 chk("t2_full_same_cycle", 64'(bus.ifu_mstReq_valid), 64'h0);
        tick();
        chk("t2_fv", 64'(bus.fetch_valid), 64'h1);
        chk("t2_pc", bus.fetch_pc, 64'h1000);
        bus.ifu_slvRsp_valid = 1'b0;
        #1 chk("t2_reissue", 64'(bus.ifu_mstReq_valid), 64'h1);
        tick();
        bus.fetch_addr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.ifu_slvRsp_valid = 1'b1;
            bus.ifu_data_r       = 64'(k);
            tick();
            chk($sformatf("t2_drain_pc%0d", k), bus.fetch_pc, 64'h1008 + 64'(8 * k));
        end
        bus.ifu_slvRsp_valid = 1'b0;
        tick();
        chk("t2_fv_low", 64'(bus.fetch_valid), 64'h0);

        // IQ free-space throttling
        bus.iq_free          = 5'd2;
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h3000;
        #1 chk("t3_iss0", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_qout = 64'h3008;
        #1 chk("t3_iss1", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_qout = 64'h3010;
        #1 chk("t3_iq_block", 64'(bus.fetch_addr_ready), 64'h0);
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h30;
        tick();
        chk("t3_pc0", bus.fetch_pc, 64'h3000);
        bus.ifu_slvRsp_valid = 1'b0;
        bus.fetch_addr_valid = 1'b1;
        #1 chk("t3_fv_blocks", 64'(bus.fetch_addr_ready), 64'h0);
        tick();
        #1 chk("t3_fv_clear", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h31;
        tick();
        chk("t3_pc1", bus.fetch_pc, 64'h3008);
        bus.ifu_data_r = 64'h32;
        tick();
        chk("t3_pc2", bus.fetch_pc, 64'h3010);
        bus.ifu_slvRsp_valid = 1'b0;
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h3018;
        #1 chk("t3_fv_allows_one", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h33;
        tick();
        chk("t3_pc3", bus.fetch_pc, 64'h3018);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();

        // Flush with three requests in flight
        bus.iq_free          = 5'd8;
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h100;
        tick();
        bus.fetch_addr_qout = 64'h108;
        tick();
        bus.fetch_addr_qout = 64'h110;
        tick();
        bus.fetch_addr_qout = 64'h200;
        bus.flush           = 1'b1;
        #1 chk("t4_flush_noreq", 64'(bus.ifu_mstReq_valid), 64'h0);
        tick();
        bus.flush = 1'b0;
        #1 chk("t4_post_flush_issue", 64'(bus.fetch_addr_ready), 64'h1);
        tick();
        bus.fetch_addr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.ifu_slvRsp_valid = 1'b1;
            bus.ifu_data_r       = 64'hA0 + 64'(k);
            tick();
            chk($sformatf("t4_fv%0d", k), 64'(bus.fetch_valid), (k == 3) ? 64'h1 : 64'h0);
        end
        chk("t4_pc", bus.fetch_pc, 64'h200);
        chk("t4_instr", bus.fetch_instr, 64'hA3);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();

        // Response in the flush cycle is consumed, not delivered
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h400;
        tick();
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h44;
        bus.flush            = 1'b1;
        tick();
        chk("t5_flush_rsp_fv", 64'(bus.fetch_valid), 64'h0);
        chk("t5_flush_rsp_inflight", 64'(dut.inflight_r), 64'h0);
        bus.ifu_slvRsp_valid = 1'b0;
        bus.flush            = 1'b0;

        // Simultaneous issue and response across pointer wrap
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h500;
        tick();
        for (int k = 1; k <= 8; k++) begin
            bus.fetch_addr_qout  = 64'h500 + 64'(8 * k);
            bus.ifu_slvRsp_valid = 1'b1;
            bus.ifu_data_r       = 64'(k);
            #1 chk($sformatf("t5_wrap_ready%0d", k), 64'(bus.fetch_addr_ready), 64'h1);
            tick();
            chk($sformatf("t5_wrap_pc%0d", k), bus.fetch_pc, 64'h500 + 64'(8 * (k - 1)));
            chk($sformatf("t5_wrap_instr%0d", k), bus.fetch_instr, 64'(k));
            chk($sformatf("t5_wrap_inflight%0d", k), 64'(dut.inflight_r), 64'h1);
        end
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_data_r       = 64'h9;
        tick();
        chk("t5_wrap_last_pc", bus.fetch_pc, 64'h540);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();

        // Orphan response sets sticky rsp_err
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h66;
        #1 chk("t6_err_before", 64'(bus.rsp_err), 64'h0);
        tick();
        chk("t6_err_set", 64'(bus.rsp_err), 64'h1);
        chk("t6_fv", 64'(bus.fetch_valid), 64'h0);
        chk("t6_pc_hold", bus.fetch_pc, 64'h540);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();
        chk("t6_err_held", 64'(bus.rsp_err), 64'h1);
        chk("t6_inflight", 64'(dut.inflight_r), 64'h0);
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h600;
        tick();
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h60;
        tick();
        chk("t6_after_fv", 64'(bus.fetch_valid), 64'h1);
        chk("t6_after_pc", bus.fetch_pc, 64'h600);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();

        // Asynchronous reset mid-burst
        bus.fetch_addr_valid = 1'b1;
        bus.fetch_addr_qout  = 64'h700;
        tick();
        bus.fetch_addr_qout = 64'h708;
        tick();
        bus.fetch_addr_valid = 1'b0;
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h70;
        tick();
        chk("t7_fv_pre", 64'(bus.fetch_valid), 64'h1);
        RSTn = 1'b0;
        #1;
        chk("t7_rst_fv", 64'(bus.fetch_valid), 64'h0);
        chk("t7_rst_pc", bus.fetch_pc, RST_PC);
        chk("t7_rst_instr", bus.fetch_instr, 64'h0);
        chk("t7_rst_err", 64'(bus.rsp_err), 64'h0);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();
        bus.ifu_slvRsp_valid = 1'b1;
        bus.ifu_data_r       = 64'h71;
        tick();
        chk("t7_late_rsp_err", 64'(bus.rsp_err), 64'h1);
        chk("t7_late_rsp_fv", 64'(bus.fetch_valid), 64'h0);
        bus.ifu_slvRsp_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
